// File: rtl/bp_access_if.sv
// bp_access_if: lookup, update-queue and predictor-port signals of bp_access_ctrl
interface bp_access_if;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        bp_reset;
  logic [31:0] bp_pc;
  logic        bp_update_en;
  logic        bp_update_val;
  logic        bp_prediction;
  modport master (
    output lk_valid, lk_pc, flush, upd_valid, upd_pc, upd_taken, bp_prediction,
    input  lk_ready, pred_valid, pred_taken, upd_ready, bp_reset, bp_pc, bp_update_en, bp_update_val
  );
  modport slave (
    input  lk_valid, lk_pc, flush, upd_valid, upd_pc, upd_taken, bp_prediction,
    output lk_ready, pred_valid, pred_taken, upd_ready, bp_reset, bp_pc, bp_update_en, bp_update_val
  );
endinterface

// File: rtl/bp_access_ctrl.sv
// bp_access_ctrl: arbitrates fetch lookups and queued resolved-branch updates onto the predictor pc port
module bp_access_ctrl #(
  parameter int UQ_DEPTH      = 4,
  parameter int MAX_LK_STREAK = 3,
  parameter int INIT_CYCLES   = 2
) (
  input logic        clk,
  input logic        reset_n,
  bp_access_if.slave bus
);
  localparam int AW = $clog2(UQ_DEPTH);
  localparam int SW = $clog2(MAX_LK_STREAK + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  typedef enum logic [2:0] {INIT, IDLE, LK_RD, LK_WAIT, LK_RESP, UP_RD, UP_WR} state_t;
  state_t              state, state_n;
  logic [31:0]         q_pc [UQ_DEPTH];
  logic [UQ_DEPTH-1:0] q_tk;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [SW-1:0]       streak;
  logic [IW-1:0]       init_cnt;
  logic [31:0]         pc_q;
  logic                val_q, flushed;
  logic                empty, full, idle, grant, accept, push, upd_ready, pred_valid;
  assign empty      = wr_ptr == rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign idle       = state == IDLE;
  assign grant      = idle && !empty && (full || streak == SW'(MAX_LK_STREAK) || !bus.lk_valid);
  assign accept     = idle && !grant && bus.lk_valid;
  assign upd_ready  = state != INIT && !full;
  assign push       = bus.upd_valid && upd_ready;
  assign pred_valid = state == LK_RESP && !flushed && !bus.flush;
  assign bus.lk_ready      = idle && !grant;
  assign bus.upd_ready     = upd_ready;
  assign bus.pred_valid    = pred_valid;
  assign bus.pred_taken    = pred_valid && bus.bp_prediction;
  assign bus.bp_reset      = state == INIT;
  assign bus.bp_pc         = pc_q;
  assign bus.bp_update_en  = state == UP_WR;
  assign bus.bp_update_val = state == UP_WR && val_q;
  // next state: fixed-length lookup/update sequences launched from IDLE
  always_comb begin
    state_n = state;
    case (state)
      INIT:    state_n = init_cnt == IW'(INIT_CYCLES - 1) ? IDLE : INIT;
      IDLE:    state_n = grant ? UP_RD : accept ? LK_RD : IDLE;
      LK_RD:   state_n = LK_WAIT;
      LK_WAIT: state_n = LK_RESP;
      LK_RESP: state_n = IDLE;
      UP_RD:   state_n = UP_WR;
      UP_WR:   state_n = IDLE;
      default: state_n = INIT;
    endcase
  end
  // control state, queue pointers, streak and the captured access operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      init_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      streak   <= '0;
      pc_q     <= '0;
      val_q    <= 1'b0;
      flushed  <= 1'b0;
    end else begin
      state    <= state_n;
      init_cnt <= state == INIT ? init_cnt + 1'b1 : '0;
      wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= grant ? rd_ptr + 1'b1 : rd_ptr;
      streak   <= (grant || empty) ? '0 : accept ? streak + 1'b1 : streak;
      pc_q     <= grant ? q_pc[rd_ptr[AW-1:0]] : accept ? bus.lk_pc : pc_q;
      val_q    <= grant ? q_tk[rd_ptr[AW-1:0]] : val_q;
      flushed  <= accept ? 1'b0 : (bus.flush && (state == LK_RD || state == LK_WAIT)) ? 1'b1 : flushed;
    end
  end
  // update queue storage
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr[AW-1:0]] <= bus.upd_pc;
      q_tk[wr_ptr[AW-1:0]] <= bus.upd_taken;
    end
  end
endmodule

// File: tb/tb_bp_access_ctrl.sv
// tb_bp_access_ctrl: directed and random stimulus checked cycle by cycle against a queue-based model
module tb_bp_access_ctrl;
  localparam int UQ_DEPTH = 4;
  localparam int MAX_LK_STREAK = 3;
  localparam int INIT_CYCLES = 2;
  typedef struct {logic [31:0] pc; logic tk;} ent_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bp_access_if bus();
  bp_access_ctrl #(.UQ_DEPTH(UQ_DEPTH), .MAX_LK_STREAK(MAX_LK_STREAK), .INIT_CYCLES(INIT_CYCLES))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  ent_t        mq[$];
  int          m_init, m_phase, m_streak;
  bit          m_up, m_tk, m_flushed;
  logic [31:0] m_pc;
  bit          dut_acc, dut_push, dut_upd_en;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_init = INIT_CYCLES;
    m_phase = 0;
    m_streak = 0;
    m_up = 0;
    m_tk = 0;
    m_flushed = 0;
    m_pc = '0;
  endtask
  task automatic step();
    bit in_init, idle, full, want_up, e_lkr, e_updr, e_pv, e_ue;
    int qn;
    ent_t e;
    #1;
    if (!reset_n) model_reset();
    in_init = m_init > 0;
    idle = !in_init && m_phase == 0;
    qn = mq.size();
    full = qn == UQ_DEPTH;
    want_up = idle && qn > 0 && (full || m_streak == MAX_LK_STREAK || !bus.lk_valid);
    e_lkr = idle && !want_up;
    e_updr = !in_init && !full;
    e_pv = !m_up && m_phase == 3 && !m_flushed && !bus.flush;
    e_ue = m_up && m_phase == 2;
    chk("bp_reset", bus.bp_reset, in_init);
    chk("lk_ready", bus.lk_ready, e_lkr);
    chk("upd_ready", bus.upd_ready, e_updr);
    chk("pred_valid", bus.pred_valid, e_pv);
    chk("pred_taken", bus.pred_taken, e_pv && bus.bp_prediction);
    chk("bp_pc", bus.bp_pc, m_pc);
    chk("bp_update_en", bus.bp_update_en, e_ue);
    chk("bp_update_val", bus.bp_update_val, e_ue && m_tk);
    dut_acc = bus.lk_valid && bus.lk_ready;
    dut_push = bus.upd_valid && bus.upd_ready;
    dut_upd_en = bus.bp_update_en;
    if (reset_n) begin
      if (in_init) m_init--;
      else if (idle) begin
        if (want_up) begin
          e = mq.pop_front();
          m_pc = e.pc;
          m_tk = e.tk;
          m_up = 1;
          m_phase = 1;
        end else if (bus.lk_valid) begin
          m_pc = bus.lk_pc;
          m_up = 0;
          m_phase = 1;
          m_flushed = 0;
        end
      end else begin
        if (!m_up && m_phase < 3 && bus.flush) m_flushed = 1;
        m_phase = (m_phase == (m_up ? 2 : 3)) ? 0 : m_phase + 1;
      end
      m_streak = (want_up || qn == 0) ? 0 : m_streak + ((e_lkr && bus.lk_valid) ? 1 : 0);
      if (bus.upd_valid && e_updr) mq.push_back('{bus.upd_pc, bus.upd_taken});
    end
    @(negedge clk);
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    int n, guard;
    bus.lk_valid = 0;
    bus.lk_pc = '0;
    bus.flush = 0;
    bus.upd_valid = 0;
    bus.upd_pc = '0;
    bus.upd_taken = 0;
    bus.bp_prediction = 0;
    model_reset();
    @(negedge clk);
    steps(2);
    reset_n = 1;
    steps(INIT_CYCLES);
    // single lookup with taken prediction
    bus.lk_valid = 1;
    bus.lk_pc = 32'h1000;
    bus.bp_prediction = 1;
    step();
    bus.lk_valid = 0;
    steps(4);
    // single update with no competing lookup
    bus.upd_valid = 1;
    bus.upd_pc = 32'h2004;
    bus.upd_taken = 1;
    step();
    bus.upd_valid = 0;
    steps(4);
    // fill the queue past capacity while lookups keep requesting
    bus.lk_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.upd_valid = 1;
      bus.upd_pc = 32'h3000 + 32'(i * 4);
      bus.upd_taken = i[0];
      guard = 0;
      do begin
        step();
        guard++;
      end while (!dut_push && guard < 20);
      chk("push_accepted", 32'(dut_push), 32'd1);
    end
    bus.upd_valid = 0;
    steps(40);
    bus.lk_valid = 0;
    steps(20);
    // streak limit: one queued update against continuous lookups
    bus.lk_valid = 1;
    bus.lk_pc = 32'h4000;
    bus.upd_valid = 1;
    bus.upd_pc = 32'h4400;
    bus.upd_taken = 0;
    step();
    bus.upd_valid = 0;
    n = 0;
    guard = 0;
    while (!dut_upd_en && guard < 60) begin
      step();
      n += dut_acc ? 1 : 0;
      guard++;
    end
    chk("streak_lookups", n, MAX_LK_STREAK);
    steps(12);
    bus.lk_valid = 0;
    steps(4);
    // flush during LK_WAIT, then a normal lookup
    bus.lk_valid = 1;
    bus.lk_pc = 32'h5000;
    step();
    bus.lk_valid = 0;
    step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    steps(2);
    bus.lk_valid = 1;
    bus.lk_pc = 32'h6000;
    bus.bp_prediction = 0;
    step();
    bus.lk_valid = 0;
    steps(4);
    // reset during UP_RD with a second entry still queued
    bus.upd_valid = 1;
    bus.upd_pc = 32'h7000;
    bus.upd_taken = 1;
    step();
    bus.upd_pc = 32'h7004;
    step();
    bus.upd_valid = 0;
    reset_n = 0;
    steps(2);
    reset_n = 1;
    steps(10);
    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      bus.lk_valid = ($urandom_range(0, 3) != 0);
      bus.lk_pc = $urandom;
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.upd_valid = ($urandom_range(0, 2) == 0);
      bus.upd_pc = $urandom;
      bus.upd_taken = $urandom_range(0, 1);
      bus.bp_prediction = $urandom_range(0, 1);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
